spi_flash_ctrl: RTL and testbench

Memory-mapped SPI master peripheral on the SoC data bus. It drives the boot flash pins (`flash_clk`, `flash_csn`, `flash_io0`, `flash_io1`) in single-bit SPI mode 0. Software issues flash commands byte-by-byte through a small register file and polls for completion. It sits downstream of the top-level address decoder alongside `ram`, `uart` and `timer`, and its read data is ORed into the shared read-value bus.

---
 rtl/spi_flash_ctrl.sv | 94 +++++++++
 tb/tb_spi_flash_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: memory-mapped mode-0 SPI master for the boot flash, byte-at-a-time with polled status
module spi_flash_ctrl #(
  parameter logic [7:0] DIV_RESET = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [63:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [63:0] write_value_in,
  output logic        flash_clk,
  output logic        flash_csn,
  output logic        flash_io0_out,
  output logic        flash_io0_en,
  output logic        flash_io1_en,
  input  logic        flash_io1_in
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  state_t state, state_nx;
  logic cs, rx_valid, overrun, mosi, busy, sck;
  logic [7:0] div, tx, rx, rx_byte, halfcnt;
  logic [2:0] bitcnt;
  logic [1:0] idx;
  logic wr, rd, half_done, done, start;
  logic unused_bits;
  assign unused_bits = ^{address_in[63:4], address_in[1:0], write_value_in[63:8]};
  assign idx = address_in[3:2];
  assign wr = sel_in && |write_mask_in;
  assign rd = sel_in && read_in;
  assign half_done = halfcnt == div;
  assign start = wr && idx == 2'd1 && !busy;
  assign done = state == HIGH && half_done && bitcnt == 3'd0;
  assign flash_clk = sck;
  assign flash_csn = ~cs;
  assign flash_io0_en = cs;
  assign flash_io0_out = mosi;
  assign flash_io1_en = 1'b0;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next state: each SCK half-period lasts div+1 cycles, eight bits MSB first
  always_comb
    state_nx = state == IDLE ? (start ? LOW : IDLE) :
               state == LOW  ? (half_done ? HIGH : LOW) :
               half_done ? (bitcnt == 3'd0 ? IDLE : LOW) : HIGH;
  // state-decoded outputs
  always_comb begin
    busy = state != IDLE;
    sck = state == HIGH;
  end
  // register file, shift registers and half-period counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cs <= 1'b0;
      div <= DIV_RESET;
      tx <= 8'd0;
      rx <= 8'd0;
      rx_byte <= 8'd0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
      mosi <= 1'b0;
      bitcnt <= 3'd0;
      halfcnt <= 8'd0;
    end else begin
      if (wr && idx == 2'd0) cs <= write_value_in[0];
      if (wr && idx == 2'd3 && !busy) div <= write_value_in[7:0];
      overrun <= (done && rx_valid) || (wr && busy && (idx == 2'd1 || idx == 2'd3)) ||
                 (overrun && !(wr && idx == 2'd2 && write_value_in[2]));
      rx_valid <= done || (rx_valid && !(rd && idx == 2'd1));
      if (done) rx_byte <= rx;
      halfcnt <= (state == IDLE || half_done) ? 8'd0 : halfcnt + 8'd1;
      if (start) begin
        tx <= write_value_in[7:0];
        mosi <= write_value_in[7];
        bitcnt <= 3'd7;
      end
      if (state == LOW && half_done) rx <= {rx[6:0], flash_io1_in};
      if (state == HIGH && half_done && bitcnt != 3'd0) begin
        bitcnt <= bitcnt - 3'd1;
        tx <= {tx[6:0], 1'b0};
        mosi <= tx[6];
      end
    end
  end
  // read mux, zero when not selected
  always_comb
    read_value_out = !sel_in      ? 64'd0 :
                     idx == 2'd0  ? {63'd0, cs} :
                     idx == 2'd1  ? {56'd0, rx_byte} :
                     idx == 2'd2  ? {61'd0, overrun, rx_valid, busy} :
                                    {56'd0, div};
endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: directed self-checking bench for spi_flash_ctrl
module tb_spi_flash_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] address_in = '0;
  logic sel_in = 1'b0;
  logic read_in = 1'b0;
  logic [63:0] read_value_out;
  logic [3:0] write_mask_in = '0;
  logic [63:0] write_value_in = '0;
  logic flash_clk, flash_csn, flash_io0_out, flash_io0_en, flash_io1_en, flash_io1_in;
  logic loop_en = 1'b0;
  logic miso_val = 1'b0;
  int vec = 0;
  int errs = 0;
  logic [63:0] v;
  int dur, rises, hi, first;
  logic [7:0] bits;

  spi_flash_ctrl dut (
    .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in), .read_in(read_in),
    .read_value_out(read_value_out), .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .flash_clk(flash_clk), .flash_csn(flash_csn), .flash_io0_out(flash_io0_out),
    .flash_io0_en(flash_io0_en), .flash_io1_en(flash_io1_en), .flash_io1_in(flash_io1_in)
  );

  assign flash_io1_in = loop_en ? flash_io0_out : miso_val;
  always #5 clk = ~clk;

  // all tasks start and end on a falling edge
  task automatic bus_write(input logic [1:0] idx, input logic [63:0] val);
    sel_in = 1'b1; address_in = {60'd0, idx, 2'b00}; write_mask_in = 4'hf; write_value_in = val;
    @(negedge clk);
    sel_in = 1'b0; write_mask_in = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] idx, input logic rd, output logic [63:0] val);
    sel_in = 1'b1; address_in = {60'd0, idx, 2'b00}; read_in = rd;
    #1 val = read_value_out;
    @(negedge clk);
    sel_in = 1'b0; read_in = 1'b0;
  endtask

  // polls STATUS.busy each cycle, measuring duration and the SCK/MOSI waveform
  task automatic run_xfer(output int d, output int r, output int h, output int f, output logic [7:0] b);
    logic prev;
    sel_in = 1'b1; address_in = 64'h8; read_in = 1'b0; write_mask_in = 4'h0;
    #1;
    d = 0; r = 0; h = 0; f = -1; b = 8'h00; prev = 1'b0;
    while (read_value_out[0] && d < 5000) begin
      if (flash_clk) begin
        h++;
        if (!prev) begin
          r++; b = {b[6:0], flash_io0_out};
          if (f < 0) f = d;
        end
      end
      prev = flash_clk;
      @(negedge clk);
      #1 d++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vec++; if (flash_csn !== 1'b1) begin errs++; $display("FAIL rst_csn: got %b want 1", flash_csn); end
    vec++; if ({flash_clk, flash_io0_out, flash_io0_en, flash_io1_en} !== 4'b0000) begin errs++; $display("FAIL rst_pins: got %b want 0000", {flash_clk, flash_io0_out, flash_io0_en, flash_io1_en}); end
    reset = 1'b0;
    bus_read(2'd3, 1'b0, v);
    vec++; if (v !== 64'd1) begin errs++; $display("FAIL rst_div: got %h want 1", v); end
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd0) begin errs++; $display("FAIL rst_status: got %h want 0", v); end
    miso_val = 1'b1;
    bus_write(2'd3, 64'd3);
    bus_write(2'd0, 64'd1);
    bus_write(2'd1, 64'h9f);
    repeat (6) @(negedge clk);
    vec++; if ({flash_clk, flash_csn} !== 2'b10) begin errs++; $display("FAIL mid_xfer: got clk/csn %b want 10", {flash_clk, flash_csn}); end
    reset = 1'b1;
    @(negedge clk);
    vec++; if ({flash_csn, flash_clk, flash_io0_out, flash_io0_en} !== 4'b1000) begin errs++; $display("FAIL abort_pins: got %b want 1000", {flash_csn, flash_clk, flash_io0_out, flash_io0_en}); end
    reset = 1'b0;
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd0) begin errs++; $display("FAIL abort_status: got %h want 0", v); end
    bus_read(2'd3, 1'b0, v);
    vec++; if (v !== 64'd1) begin errs++; $display("FAIL abort_div: got %h want 1", v); end
    bus_read(2'd0, 1'b0, v);
    vec++; if (v !== 64'd0) begin errs++; $display("FAIL abort_ctrl: got %h want 0", v); end
    bus_read(2'd1, 1'b0, v);
    vec++; if (v !== 64'd0) begin errs++; $display("FAIL abort_data: got %h want 0", v); end
  endtask

  task automatic test_loopback;
    loop_en = 1'b1;
    bus_write(2'd3, 64'd0);
    bus_write(2'd0, 64'd1);
    bus_write(2'd1, 64'ha5);
    run_xfer(dur, rises, hi, first, bits);
    vec++; if (dur !== 16) begin errs++; $display("FAIL lb_busy_len: got %0d want 16", dur); end
    vec++; if (rises !== 8 || hi !== 8) begin errs++; $display("FAIL lb_sck: got rises %0d high %0d want 8 8", rises, hi); end
    vec++; if (first !== 1) begin errs++; $display("FAIL lb_first_rise: got %0d want 1", first); end
    vec++; if (bits !== 8'ha5) begin errs++; $display("FAIL lb_mosi: got %h want a5", bits); end
    vec++; if ({flash_csn, flash_io0_en} !== 2'b01) begin errs++; $display("FAIL lb_cs: got %b want 01", {flash_csn, flash_io0_en}); end
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd2) begin errs++; $display("FAIL lb_status: got %h want 2", v); end
    bus_read(2'd1, 1'b1, v);
    vec++; if (v !== 64'ha5) begin errs++; $display("FAIL lb_data: got %h want a5", v); end
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd0) begin errs++; $display("FAIL lb_rxv_clear: got %h want 0", v); end
  endtask

  task automatic test_divider;
    loop_en = 1'b0; miso_val = 1'b1;
    bus_write(2'd3, 64'd3);
    bus_write(2'd1, 64'h9f);
    run_xfer(dur, rises, hi, first, bits);
    vec++; if (dur !== 64) begin errs++; $display("FAIL div_busy_len: got %0d want 64", dur); end
    vec++; if (rises !== 8 || hi !== 32) begin errs++; $display("FAIL div_sck: got rises %0d high %0d want 8 32", rises, hi); end
    vec++; if (first !== 4) begin errs++; $display("FAIL div_first_rise: got %0d want 4", first); end
    vec++; if (bits !== 8'h9f) begin errs++; $display("FAIL div_mosi: got %h want 9f", bits); end
    bus_read(2'd1, 1'b1, v);
    vec++; if (v !== 64'hff) begin errs++; $display("FAIL div_data: got %h want ff", v); end
  endtask

  task automatic test_overrun;
    loop_en = 1'b1;
    bus_write(2'd3, 64'd0);
    bus_write(2'd1, 64'h03);
    bus_write(2'd1, 64'h55);
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd5) begin errs++; $display("FAIL ovr_status: got %h want 5", v); end
    bus_write(2'd2, 64'h4);
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd1) begin errs++; $display("FAIL ovr_w1c: got %h want 1", v); end
    run_xfer(dur, rises, hi, first, bits);
    vec++; if (dur !== 12) begin errs++; $display("FAIL ovr_busy_len: got %0d want 12", dur); end
    vec++; if (bits !== 8'h03) begin errs++; $display("FAIL ovr_mosi_tail: got %h want 03", bits); end
    bus_read(2'd1, 1'b1, v);
    vec++; if (v !== 64'h03) begin errs++; $display("FAIL ovr_data: got %h want 03", v); end
  endtask

  task automatic test_unread;
    loop_en = 1'b1;
    bus_write(2'd1, 64'h3c);
    run_xfer(dur, rises, hi, first, bits);
    vec++; if (dur !== 16) begin errs++; $display("FAIL unr_busy_len: got %0d want 16", dur); end
    bus_write(2'd1, 64'hc3);
    sel_in = 1'b0;
    repeat (15) @(negedge clk);
    bus_read(2'd1, 1'b1, v);
    vec++; if (v !== 64'h3c) begin errs++; $display("FAIL unr_first: got %h want 3c", v); end
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd6) begin errs++; $display("FAIL unr_status: got %h want 6", v); end
    bus_read(2'd1, 1'b0, v);
    vec++; if (v !== 64'hc3) begin errs++; $display("FAIL unr_second: got %h want c3", v); end
    bus_write(2'd2, 64'h4);
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd2) begin errs++; $display("FAIL unr_w1c: got %h want 2", v); end
    bus_write(2'd1, 64'h5a);
    bus_write(2'd3, 64'd5);
    bus_read(2'd3, 1'b0, v);
    vec++; if (v !== 64'd0) begin errs++; $display("FAIL busy_div_write: got %h want 0", v); end
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd7) begin errs++; $display("FAIL busy_div_status: got %h want 7", v); end
    run_xfer(dur, rises, hi, first, bits);
    vec++; if (dur !== 13) begin errs++; $display("FAIL busy_div_len: got %0d want 13", dur); end
    bus_read(2'd1, 1'b0, v);
    vec++; if (v !== 64'h5a) begin errs++; $display("FAIL busy_div_data: got %h want 5a", v); end
  endtask

  task automatic test_select;
    for (int i = 0; i < 4; i++) begin
      sel_in = 1'b0; read_in = 1'b1; address_in = 64'(i) << 2; write_mask_in = 4'hf;
      write_value_in = (i == 1) ? 64'h11 : (i == 3) ? 64'd7 : (i == 2) ? 64'h4 : 64'd0;
      #1;
      vec++; if (read_value_out !== 64'd0) begin errs++; $display("FAIL nosel_read%0d: got %h want 0", i, read_value_out); end
      @(negedge clk);
    end
    read_in = 1'b0; write_mask_in = 4'h0;
    bus_read(2'd0, 1'b0, v);
    vec++; if (v !== 64'd1) begin errs++; $display("FAIL nosel_ctrl: got %h want 1", v); end
    bus_read(2'd2, 1'b0, v);
    vec++; if (v !== 64'd6) begin errs++; $display("FAIL nosel_status: got %h want 6", v); end
    bus_read(2'd3, 1'b0, v);
    vec++; if (v !== 64'd0) begin errs++; $display("FAIL nosel_div: got %h want 0", v); end
    bus_read(2'd1, 1'b0, v);
    vec++; if (v !== 64'h5a) begin errs++; $display("FAIL nosel_data: got %h want 5a", v); end
    bus_write(2'd1, 64'h81);
    bus_write(2'd0, 64'd0);
    vec++; if ({flash_csn, flash_io0_en} !== 2'b10) begin errs++; $display("FAIL cs_drop: got %b want 10", {flash_csn, flash_io0_en}); end
    run_xfer(dur, rises, hi, first, bits);
    vec++; if (dur !== 15 || rises !== 8) begin errs++; $display("FAIL cs_drop_sck: got len %0d rises %0d want 15 8", dur, rises); end
  endtask

  task automatic test_back_to_back;
    loop_en = 1'b1;
    bus_write(2'd1, 64'hf0);
    run_xfer(dur, rises, hi, first, bits);
    bus_write(2'd1, 64'h0f);
    run_xfer(dur, rises, hi, first, bits);
    vec++; if (dur !== 16 || bits !== 8'h0f) begin errs++; $display("FAIL b2b: got len %0d mosi %h want 16 0f", dur, bits); end
    bus_read(2'd1, 1'b1, v);
    vec++; if (v !== 64'h0f) begin errs++; $display("FAIL b2b_data: got %h want 0f", v); end
  endtask

  initial begin
    test_reset;
    test_loopback;
    test_divider;
    test_overrun;
    test_unread;
    test_select;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
